// File: rtl/game_pkg.sv
// game_pkg: shared sprite/game constants, character box geometry,
// collision-scanner state type and colour helper.
package game_pkg;

  localparam int COORD_W = 9;
  localparam logic [2:0] BG_COLOUR = 3'b111;

  localparam int CHAR_LEFT_OFF = 3;
  localparam int CHAR_TOP_OFF = 5;
  localparam int CHAR_BOX_W = 14;
  localparam int CHAR_BOX_H = 17;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scan_state_t;

  function automatic logic opaque(input logic [2:0] c);
    return c != BG_COLOUR;
  endfunction

endpackage

// File: rtl/character_collision_scanner_if.sv
// Scanner bus: control (start/busy/done/result), character anchor,
// coordinate out to renderer/map and their returned colours.
interface character_collision_scanner_if;
  import game_pkg::*;

  logic start;
  coord_t character_x_position;
  coord_t character_y_position;
  coord_t x_cord;
  coord_t y_cord;
  logic [2:0] flag;
  logic [2:0] map_colour;
  logic busy;
  logic done;
  logic collision;
  coord_t hit_x;
  coord_t hit_y;

  modport master (
    input start,
    input character_x_position,
    input character_y_position,
    input flag,
    input map_colour,
    output x_cord,
    output y_cord,
    output busy,
    output done,
    output collision,
    output hit_x,
    output hit_y
  );

  modport slave (
    output start,
    output character_x_position,
    output character_y_position,
    output flag,
    output map_colour,
    input x_cord,
    input y_cord,
    input busy,
    input done,
    input collision,
    input hit_x,
    input hit_y
  );

endinterface

// File: rtl/raster_counter.sv
// raster_counter: 2-D col/row offset counter, col wraps at BOX_W-1.
// Ports: clock, reset, clear, enable; col_nxt/row_nxt (post-step), last.
module raster_counter #(
  parameter int BOX_W = 14,
  parameter int BOX_H = 17,
  parameter int COL_W = $clog2(BOX_W),
  parameter int ROW_W = $clog2(BOX_H)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [COL_W-1:0] col_nxt,
  output logic [ROW_W-1:0] row_nxt,
  output logic             last
);

  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic col_wrap;

  assign col_wrap = col_q == COL_W'(BOX_W - 1);
  assign last = col_wrap && (row_q == ROW_W'(BOX_H - 1));

  always_comb begin
    col_nxt = col_q + COL_W'(1);
    row_nxt = row_q;
    if (col_wrap) begin
      col_nxt = '0;
      row_nxt = row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (enable) begin
      col_q <= col_nxt;
      row_q <= row_nxt;
    end
  end

endmodule

// File: rtl/character_collision_scanner.sv
// Sweeps the character box in raster order, compares renderer flag with map
// colour one cycle later. Ports: clock, reset, bus (scanner master side).
module character_collision_scanner
  import game_pkg::*;
(
  input logic clock,
  input logic reset,
  character_collision_scanner_if.master bus
);

  localparam int COL_W = $clog2(CHAR_BOX_W);
  localparam int ROW_W = $clog2(CHAR_BOX_H);

  scan_state_t state_q, state_d;

  coord_t base_x, base_y;
  coord_t x_q, y_q;
  coord_t d_x, d_y;
  coord_t hx_q, hy_q;
  coord_t start_x, start_y;
  logic d_v;
  logic coll_q;
  logic accept, step, last, hit;
  logic [COL_W-1:0] col_nxt;
  logic [ROW_W-1:0] row_nxt;

  assign accept = (state_q == IDLE) && bus.start;
  assign step = (state_q == SCAN) && !last;
  assign start_x = bus.character_x_position - coord_t'(CHAR_LEFT_OFF);
  assign start_y = bus.character_y_position - coord_t'(CHAR_TOP_OFF);
  assign hit = d_v && opaque(bus.flag) && opaque(bus.map_colour);

  // Counter holds offsets of the coordinate now on x_cord/y_cord;
  // coordinate 0 is issued straight from the anchor on the start edge.
  raster_counter #(
    .BOX_W (CHAR_BOX_W),
    .BOX_H (CHAR_BOX_H)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept),
    .enable  (step),
    .col_nxt (col_nxt),
    .row_nxt (row_nxt),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_x <= '0;
      base_y <= '0;
      x_q    <= '0;
      y_q    <= '0;
      d_x    <= '0;
      d_y    <= '0;
      d_v    <= 1'b0;
      coll_q <= 1'b0;
      hx_q   <= '0;
      hy_q   <= '0;
    end else begin
      d_v <= state_q == SCAN;
      d_x <= x_q;
      d_y <= y_q;
      if (accept) begin
        base_x <= start_x;
        base_y <= start_y;
        x_q    <= start_x;
        y_q    <= start_y;
        coll_q <= 1'b0;
        hx_q   <= '0;
        hy_q   <= '0;
      end else begin
        if (step) begin
          x_q <= base_x + coord_t'(col_nxt);
          y_q <= base_y + coord_t'(row_nxt);
        end
        if (hit && !coll_q) begin
          coll_q <= 1'b1;
          hx_q   <= d_x;
          hy_q   <= d_y;
        end
      end
    end
  end

  assign bus.x_cord = x_q;
  assign bus.y_cord = y_q;
  assign bus.busy = (state_q == SCAN) || (state_q == DRAIN);
  assign bus.done = state_q == DONE;
  assign bus.collision = coll_q;
  assign bus.hit_x = hx_q;
  assign bus.hit_y = hy_q;

endmodule

// File: tb/tb_character_collision_scanner.sv
// Bench for character_collision_scanner: sprite renderer and obstacle map
// models, directed scenarios plus randomized scans against a raster model.
module tb_character_collision_scanner;
  import game_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  character_collision_scanner_if bus();

  character_collision_scanner dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass = 0;
  int rx = 0;
  int ry = 0;

  typedef struct {
    int x;
    int y;
  } pt_t;
  pt_t map_q[$];

  int last_nd, last_mnx, last_mxx, last_mny, last_mxy;

  // Sprite: 14x17 box anchored 3 left / 5 up; a few holes in the pattern.
  function automatic logic [2:0] sprite_colour(input int x, y, ax, ay);
    int c, r;
    c = (x - ax + 3) & 511;
    r = (y - ay + 5) & 511;
    if (c < 14 && r < 17 && ((c * 7 + r * 3) % 5) != 1)
      return 3'((c + r) % 7);
    return 3'b111;
  endfunction

  function automatic logic [2:0] map_colour_of(input int x, y);
    foreach (map_q[i])
      if (map_q[i].x == x && map_q[i].y == y) return 3'((x + y) % 7);
    return 3'b111;
  endfunction

  // Reference: visit the box row by row, left to right, first overlap wins.
  function automatic void ref_scan(input int ax, ay, output bit c,
                                   output int hx, output int hy);
    int x, y;
    c = 0;
    hx = 0;
    hy = 0;
    for (int r = 0; r < 17; r++)
      for (int q = 0; q < 14; q++) begin
        x = (ax - 3 + q) & 511;
        y = (ay - 5 + r) & 511;
        if (!c && sprite_colour(x, y, ax, ay) != 3'b111 &&
            map_colour_of(x, y) != 3'b111) begin
          c = 1;
          hx = x;
          hy = y;
        end
      end
  endfunction

  always @(posedge clock) begin
    bus.flag <= sprite_colour(int'(bus.x_cord), int'(bus.y_cord), rx, ry);
    bus.map_colour <= map_colour_of(int'(bus.x_cord), int'(bus.y_cord));
  end

  initial begin
    bus.start = 1'b0;
    bus.character_x_position = '0;
    bus.character_y_position = '0;
  end

  // One full scan: xs = cycle of an extra start, rc = reset cycle,
  // mv = cycle the anchor inputs are scrambled (0 = none).
  task automatic do_scan(input int px, py, xs, rc, mv, input bit ec,
                         input int ehx, ehy, input string nm);
    int bad_busy = -1;
    int bad_done = -1;
    int bad_xy = -1;
    int bad_rst = -1;
    bit seen[int];
    last_mnx = 9999;
    last_mxx = -1;
    last_mny = 9999;
    last_mxy = -1;
    @(negedge clock);
    rx = px;
    ry = py;
    bus.character_x_position = 9'(px);
    bus.character_y_position = 9'(py);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 1; c <= 242; c++) begin
      bit eb, ed, live;
      int k, ex, ey, ax, ay;
      live = (rc == 0) || (c <= rc);
      eb = (c <= 239) && live;
      ed = (c == 240) && (rc == 0);
      if (bus.busy !== eb && bad_busy < 0) bad_busy = c;
      if (bus.done !== ed && bad_done < 0) bad_done = c;
      if (c <= 238 && live) begin
        k = c - 1;
        ex = (px - 3 + k % 14) & 511;
        ey = (py - 5 + k / 14) & 511;
        ax = int'(bus.x_cord);
        ay = int'(bus.y_cord);
        if ((ax != ex || ay != ey) && bad_xy < 0) bad_xy = c;
        seen[ay * 512 + ax] = 1;
        if (ax < last_mnx) last_mnx = ax;
        if (ax > last_mxx) last_mxx = ax;
        if (ay < last_mny) last_mny = ay;
        if (ay > last_mxy) last_mxy = ay;
      end
      if (rc != 0 && c == rc + 1) begin
        if ({bus.x_cord, bus.y_cord, bus.collision, bus.hit_x, bus.hit_y}
            !== '0) bad_rst = c;
        reset = 1'b0;
      end
      if (c == rc) reset = 1'b1;
      bus.start = (c == xs);
      if (c == mv) begin
        bus.character_x_position = 9'($urandom);
        bus.character_y_position = 9'($urandom);
      end
      @(negedge clock);
    end
    last_nd = seen.num();
    n_checks++;
    if (bad_busy >= 0)
      $display("FAIL %s busy_profile: wrong at cycle %0d, required none", nm, bad_busy);
    else n_pass++;
    n_checks++;
    if (bad_done >= 0)
      $display("FAIL %s done_profile: wrong at cycle %0d, required none", nm, bad_done);
    else n_pass++;
    n_checks++;
    if (bad_xy >= 0)
      $display("FAIL %s coord_seq: wrong at cycle %0d, required none", nm, bad_xy);
    else n_pass++;
    if (rc != 0) begin
      n_checks++;
      if (bad_rst >= 0)
        $display("FAIL %s reset_outputs: nonzero at cycle %0d, required all 0", nm, bad_rst);
      else n_pass++;
    end
    n_checks++;
    if (bus.collision !== ec)
      $display("FAIL %s collision: got %b required %b", nm, bus.collision, ec);
    else n_pass++;
    n_checks++;
    if (int'(bus.hit_x) != ehx || int'(bus.hit_y) != ehy)
      $display("FAIL %s hit: got (%0d,%0d) required (%0d,%0d)", nm,
               bus.hit_x, bus.hit_y, ehx, ehy);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset busy_done: got %b%b required 00", bus.busy, bus.done);
    else n_pass++;
    n_checks++;
    if (bus.collision !== 1'b0 || bus.hit_x !== '0 || bus.hit_y !== '0)
      $display("FAIL reset result: got %b/%0d/%0d required 0/0/0",
               bus.collision, bus.hit_x, bus.hit_y);
    else n_pass++;
    n_checks++;
    if (bus.x_cord !== '0 || bus.y_cord !== '0)
      $display("FAIL reset coord: got (%0d,%0d) required (0,0)", bus.x_cord, bus.y_cord);
    else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_empty_map();
    map_q = {};
    do_scan(100, 100, 0, 0, 0, 0, 0, 0, "empty");
    n_checks++;
    if (last_nd != 238)
      $display("FAIL empty distinct: got %0d required 238", last_nd);
    else n_pass++;
    n_checks++;
    if (last_mnx != 97 || last_mxx != 110 || last_mny != 95 || last_mxy != 111)
      $display("FAIL empty span: got x%0d..%0d y%0d..%0d required x97..110 y95..111",
               last_mnx, last_mxx, last_mny, last_mxy);
    else n_pass++;
  endtask

  task automatic test_single_hits();
    map_q = '{'{101, 95}};
    do_scan(100, 100, 0, 0, 0, 1, 101, 95, "head");
    map_q = '{'{100, 95}};
    do_scan(100, 100, 0, 0, 0, 0, 0, 0, "transparent");
    map_q = '{'{104, 110}, '{98, 96}};
    do_scan(100, 100, 0, 0, 0, 1, 98, 96, "first_hit");
  endtask

  task automatic test_ignore_and_reset();
    map_q = '{'{101, 95}};
    do_scan(100, 100, 50, 0, 0, 1, 101, 95, "start_busy");
    do_scan(100, 100, 0, 100, 0, 0, 0, 0, "reset_mid");
    do_scan(100, 100, 0, 0, 0, 1, 101, 95, "after_reset");
  endtask

  task automatic test_wrap();
    map_q = '{'{510, 509}};
    do_scan(1, 2, 0, 0, 0, 1, 510, 509, "wrap");
  endtask

  task automatic test_back_to_back();
    map_q = {};
    do_scan(200, 300, 240, 0, 0, 0, 0, 0, "start_on_done");
    map_q = '{'{201, 295}};
    do_scan(200, 300, 0, 0, 0, 1, 201, 295, "back_to_back");
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int ax, ay, n, hx, hy;
      bit c;
      pt_t p;
      ax = $urandom_range(0, 511);
      ay = $urandom_range(0, 511);
      n = $urandom_range(0, 4);
      map_q = {};
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 3) != 0) begin
          p.x = (ax - 3 + $urandom_range(0, 13)) & 511;
          p.y = (ay - 5 + $urandom_range(0, 16)) & 511;
        end else begin
          p.x = $urandom_range(0, 511);
          p.y = $urandom_range(0, 511);
        end
        map_q.push_back(p);
      end
      ref_scan(ax, ay, c, hx, hy);
      do_scan(ax, ay, $urandom_range(2, 238), 0, $urandom_range(2, 238),
              c, hx, hy, $sformatf("rand%0d", it));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_empty_map();
    test_single_hits();
    test_ignore_and_reset();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/character_collision_scanner.md
Name: character_collision_scanner

Overview:
- Reader side of the character sprite-render interface: drives pixel coordinates into the character renderer and consumes its returned 3-bit colour flag.
- On a start pulse, sweeps the character's bounding box in raster order and samples the renderer flag against an obstacle-map colour of the same pixel.
- Reports whether any opaque character pixel overlaps an opaque map pixel, and the first such pixel.
- Sits between the game-control FSM (start/done/collision) and the renderer/map lookups.

Parameters:
- COORD_W, 9, coordinate width; all coordinate arithmetic is modulo 2^COORD_W.
- BOX_W, 14, box width; column offsets -3..+10 from character_x_position.
- BOX_H, 17, box height; row offsets -5..+11 from character_y_position.
- BG_COLOUR, 3'b111, transparent/background colour code, for both renderer flag and map colour.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start  in  1  request a scan; honoured only in IDLE
- character_x_position  in  COORD_W  character anchor x
- character_y_position  in  COORD_W  character anchor y
- x_cord  out  COORD_W  registered pixel x presented to renderer and map
- y_cord  out  COORD_W  registered pixel y presented to renderer and map
- flag  in  3  renderer colour for the coordinate presented in the previous cycle
- map_colour  in  3  map colour for the coordinate presented in the previous cycle
- busy  out  1  high while a scan is in progress
- done  out  1  one-cycle pulse at scan completion
- collision  out  1  result of the last scan; held until next accepted start
- hit_x  out  COORD_W  x of first colliding pixel in raster order
- hit_y  out  COORD_W  y of first colliding pixel in raster order

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, counters 0, delay-stage valid bit 0.
- States and transitions:
  - IDLE -> SCAN on start.
  - SCAN -> DRAIN after the last coordinate is issued.
  - DRAIN -> DONE after the last sample.
  - DONE -> IDLE unconditionally.
- Start acceptance (IDLE & start):
  - Latch base_x = character_x_position - 3 and base_y = character_y_position - 5, each mod 2^COORD_W.
  - Clear collision, hit_x and hit_y. Reset column/row offsets to 0.
- SCAN issue:
  - Each cycle, register x_cord = base_x + col and y_cord = base_y + row (wrap mod 2^COORD_W).
  - col increments; at BOX_W-1, col wraps to 0 and row increments.
  - After col = BOX_W-1 and row = BOX_H-1 are issued, go to DRAIN.
- Sampling pipeline:
  - The issued coordinate and a valid bit are copied into a one-stage delay register.
  - In the following cycle, flag and map_colour belong to that delayed coordinate.
  - Hit condition: delayed valid & (flag != BG_COLOUR) & (map_colour != BG_COLOUR).
  - On the first hit of a scan: set collision=1 and capture hit_x/hit_y from the delayed coordinate. Later hits do not overwrite.
  - No early exit; the full box is always swept.
- Timing (N = BOX_W*BOX_H = 238; start sampled at edge E0):
  - Coordinate k is on x_cord/y_cord during cycle k+1.
  - The sample for coordinate k is taken at the end of cycle k+2.
  - busy is high during cycles 1..N+1.
  - done is high during cycle N+2 (= cycle 240 with defaults); collision and hit_x/hit_y are valid from cycle N+2 onward.
- Idle outputs: x_cord/y_cord hold their last value; the renderer output is don't-care while idle.
- start while busy, in DONE, or in DRAIN: ignored, no queueing.
- Position inputs changing mid-scan: ignored, because base_x/base_y are latched at start.
- Wrap-around: a box crossing coordinate 0 or 2^COORD_W-1 issues wrapped coordinates, matching the renderer's modulo-512 compares. No clipping.
- Reset mid-scan: immediate return to IDLE, all outputs 0, no done pulse.
- start asserted on the same cycle as done: ignored (FSM is in DONE). A new start is accepted the following cycle.

Decomposition:
- Shared package game_pkg:
  - COORD_W, BG_COLOUR.
  - Box offsets CHAR_LEFT_OFF=3, CHAR_TOP_OFF=5, CHAR_BOX_W=14, CHAR_BOX_H=17.
  - Scanner state enum {IDLE, SCAN, DRAIN, DONE}.
- One sub-module, raster_counter: 2-D col/row offset counter with clear, enable, col wrap and a last flag. It is reused by future sprite sweeps.

Test Plan:
- Map all BG_COLOUR, pos (100,100), pulse start -> busy for 239 cycles, done only in cycle 240, collision=0, and exactly 238 distinct coordinates spanning x 97..110, y 95..111.
- Map opaque only at (101,95) (head pixel), pos (100,100) -> collision=1, hit_x=101, hit_y=95.
- Map opaque only at (100,95) (inside box but transparent in sprite), pos (100,100) -> collision=0.
- Map opaque at (104,110) and (98,96), pos (100,100) -> hit_x=98, hit_y=96 (first in raster order).
- Pulse start again at cycle 50 -> ignored, done still at cycle 240; assert reset at cycle 100 -> outputs 0, no done; a fresh start then completes normally.
- pos (1,2), map opaque at (510,509) (left arm, wrapped) -> collision=1, hit_x=510, hit_y=509.
